alu_seq_divider: RTL and testbench

//  Multi-cycle 32-bit integer divider that drives the shared ALU's operand/opcode interface as its

---
 rtl/alu_seq_divider.sv | 129 ++++++++++++
 tb/tb_alu_seq_divider.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_divider.sv
// Multi-cycle 32-bit restoring divider that borrows the shared ALU for every subtraction.
// Handles signed/unsigned DIV/REM with valid/ready request and response handshakes.
module alu_seq_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_signed,
  input  logic [DATA_WIDTH-1:0] req_dividend,
  input  logic [DATA_WIDTH-1:0] req_divisor,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_quot,
  output logic [DATA_WIDTH-1:0] resp_rem,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_ALUop,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_CarryOut
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_DIV, S_NEG_Q, S_NEG_R, S_DONE
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] dvd;   // dividend, shifted out as the quotient shifts in
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] dsr;
  logic [CW-1:0]         cnt;
  logic                  b_neg;
  logic                  q_neg;
  logic                  r_neg;

  logic [DATA_WIDTH-1:0] shifted;
  logic                  qbit;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign resp_quot  = (state == S_DONE) ? dvd : '0;
  assign resp_rem   = (state == S_DONE) ? rem : '0;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    alu_A     = '0;
    alu_B     = '0;
    alu_ALUop = OP_AND;
    shifted   = {rem[DATA_WIDTH-2:0], dvd[DATA_WIDTH-1]};
    // rem[msb] set means the 33-bit partial remainder already exceeds any divisor.
    qbit      = rem[DATA_WIDTH-1] | ~alu_CarryOut;
    unique case (state)
      S_NEG_A, S_NEG_Q: begin alu_B = dvd; alu_ALUop = OP_SUB; end
      S_NEG_B:          begin alu_B = dsr; alu_ALUop = OP_SUB; end
      S_NEG_R:          begin alu_B = rem; alu_ALUop = OP_SUB; end
      S_DIV:            begin alu_A = shifted; alu_B = dsr; alu_ALUop = OP_SUB; end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      dvd   <= '0;
      rem   <= '0;
      dsr   <= '0;
      cnt   <= '0;
      b_neg <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (req_valid) begin
          dsr   <= req_divisor;
          cnt   <= CW'(DATA_WIDTH - 1);
          b_neg <= req_signed & req_divisor[DATA_WIDTH-1];
          q_neg <= req_signed & (req_dividend[DATA_WIDTH-1] ^ req_divisor[DATA_WIDTH-1]);
          r_neg <= req_signed & req_dividend[DATA_WIDTH-1];
          if (req_divisor == '0) begin
            dvd   <= '1;
            rem   <= req_dividend;
            state <= S_DONE;
          end else begin
            dvd <= req_dividend;
            rem <= '0;
            if (req_signed & req_dividend[DATA_WIDTH-1])     state <= S_NEG_A;
            else if (req_signed & req_divisor[DATA_WIDTH-1]) state <= S_NEG_B;
            else                                             state <= S_DIV;
          end
        end
        S_NEG_A: begin
          dvd   <= alu_Result;
          state <= b_neg ? S_NEG_B : S_DIV;
        end
        S_NEG_B: begin
          dsr   <= alu_Result;
          state <= S_DIV;
        end
        S_DIV: begin
          rem <= qbit ? alu_Result : shifted;
          dvd <= {dvd[DATA_WIDTH-2:0], qbit};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            if (q_neg)      state <= S_NEG_Q;
            else if (r_neg) state <= S_NEG_R;
            else            state <= S_DONE;
          end
        end
        S_NEG_Q: begin
          dvd   <= alu_Result;
          state <= r_neg ? S_NEG_R : S_DONE;
        end
        S_NEG_R: begin
          rem   <= alu_Result;
          state <= S_DONE;
        end
        S_DONE: if (resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Bench for alu_seq_divider: behavioural ALU, arithmetic reference model, directed and random
// requests with latency, back-pressure, throughput and mid-operation reset checks.
module tb_alu_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_signed;
  logic [31:0] req_dividend, req_divisor;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_quot, resp_rem;
  logic [31:0] alu_A, alu_B, alu_Result;
  logic [2:0]  alu_ALUop;
  logic        alu_CarryOut;

  int checks   = 0;
  int failures = 0;
  int bad_op   = 0;

  alu_seq_divider #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quot(resp_quot), .resp_rem(resp_rem),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
    .alu_Result(alu_Result), .alu_CarryOut(alu_CarryOut)
  );

  always #5 clk = ~clk;

  // Shared ALU: SUB with borrow-out, AND otherwise.
  always_comb begin
    alu_Result   = '0;
    alu_CarryOut = 1'b0;
    if (alu_ALUop == 3'b110) begin
      alu_Result   = alu_A - alu_B;
      alu_CarryOut = (alu_A < alu_B);
    end else if (alu_ALUop == 3'b000) begin
      alu_Result = alu_A & alu_B;
    end
  end

  always @(negedge clk) if (alu_ALUop != 3'b000 && alu_ALUop != 3'b110) bad_op++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: language arithmetic plus the divide-by-zero and overflow rules.
  task automatic model(input bit s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output int lat);
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 1;
    end else if (!s) begin
      q = a / b; r = a % b; lat = 33;
    end else begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
      lat = 33 + int'(a[31]) + int'(b[31]) + int'(a[31] ^ b[31]) + int'(a[31]);
    end
  endtask

  // Called just after a rising edge; returns just after the response-fire edge.
  task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] eq, er, q0, r0;
    int          elat, n;
    bit          ok;
    model(s, a, b, eq, er, elat);
    req_valid = 1'b1; req_signed = s; req_dividend = a; req_divisor = b;
    @(negedge clk);
    check("req_ready", {31'b0, req_ready}, 32'd1);
    check("idle_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 200);
    check("resp_valid", {31'b0, resp_valid}, 32'd1);
    check("latency", n, elat);
    check("quot", resp_quot, eq);
    check("rem", resp_rem, er);
    q0 = resp_quot; r0 = resp_rem; ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_quot !== q0 || resp_rem !== r0 || resp_valid !== 1'b1 ||
          req_ready !== 1'b0 || alu_ALUop !== 3'b000) ok = 1'b0;
    end
    if (hold > 0) check("hold_stable", {31'b0, ok}, 32'd1);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_signed = 1'b0;
    req_dividend = '0; req_divisor = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_quot", resp_quot, 32'd0);
    check("rst_rem", resp_rem, 32'd0);
    check("rst_alu_A", alu_A, 32'd0);
    check("rst_alu_B", alu_B, 32'd0);
    check("rst_alu_op", {29'b0, alu_ALUop}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    do_div(1'b0, 32'd100, 32'd7, 0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(1'b0, 32'h1234_5678, 32'd0, 0);
    do_div(1'b1, 32'h1234_5678, 32'd0, 0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    do_div(1'b1, 32'h8000_0000, 32'd0, 0);
    do_div(1'b0, 32'd1000, 32'd33, 10);

    // Abort in the middle of the DIV phase; no stale response may follow.
    req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'hDEAD_BEEF; req_divisor = 32'd7;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("abort_alu_op", {29'b0, alu_ALUop}, 32'd0);
    check("abort_alu_A", alu_A, 32'd0);
    @(posedge clk);
    #1;
    do_div(1'b0, 32'd9, 32'd3, 0);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 15);
        2:       b = -($urandom_range(1, 100));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      do_div(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3));
    end

    check("alu_op_legal", bad_op, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
